mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 210 +++++++++++++++++++++
 tb/tb_mem_access.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Single-entry MEM pipeline stage: issues the load/store bus request, aligns load data
// and holds the result for MEM_WB. `MEM_ALE_EN adds misaligned-access detection (out_ale).
`timescale 1ns/1ps

module mem_access #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ls_valid,
  output logic                  ts_ready,
  output logic                  ts_valid,
  input  logic                  ns_ready,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [31:0]           in_inst,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_store_data,
  input  logic [4:0]            in_rw_addr,
  input  logic                  in_rw_en,
  input  logic [3:0]            in_mem_op,
  output logic                  dreq_valid,
  input  logic                  dreq_ready,
  output logic                  dreq_we,
  output logic [ADDR_WIDTH-1:0] dreq_addr,
  output logic [3:0]            dreq_wstrb,
  output logic [DATA_WIDTH-1:0] dreq_wdata,
  input  logic                  dresp_valid,
  input  logic [DATA_WIDTH-1:0] dresp_rdata,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [31:0]           out_inst,
  output logic [DATA_WIDTH-1:0] out_rw_data,
  output logic [4:0]            out_rw_addr,
  output logic                  out_rw_en
`ifdef MEM_ALE_EN
  ,
  output logic                  out_ale
`endif
);

  localparam logic [3:0] LD_B  = 4'b0001;
  localparam logic [3:0] LD_H  = 4'b0010;
  localparam logic [3:0] LD_W  = 4'b0011;
  localparam logic [3:0] LD_BU = 4'b0100;
  localparam logic [3:0] LD_HU = 4'b0101;
  localparam logic [3:0] ST_B  = 4'b1001;
  localparam logic [3:0] ST_H  = 4'b1010;
  localparam logic [3:0] ST_W  = 4'b1011;

  typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

  state_t     state;
  logic       kill;
  logic [3:0] op_q;
  logic [1:0] lane_q;

  logic                  cap_c;
  logic                  is_load_c;
  logic                  is_store_c;
  logic                  is_mem_c;
  logic                  misalign_c;
  logic [3:0]            strb_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [7:0]            ld_byte_c;
  logic [15:0]           ld_half_c;
  logic [DATA_WIDTH-1:0] load_data_c;

  assign ts_ready   = (state == IDLE) | ((state == HOLD) & ns_ready);
  assign cap_c      = ls_valid & ts_ready & ~flush;
  assign is_load_c  = in_mem_op inside {LD_B, LD_H, LD_W, LD_BU, LD_HU};
  assign is_store_c = in_mem_op inside {ST_B, ST_H, ST_W};
  assign is_mem_c   = is_load_c | is_store_c;

`ifdef MEM_ALE_EN
  assign misalign_c = ((in_mem_op inside {LD_H, LD_HU, ST_H}) & in_alu_result[0]) |
                      ((in_mem_op inside {LD_W, ST_W}) & (|in_alu_result[1:0]));
`else
  assign misalign_c = 1'b0;
`endif

  // Store lane strobe and lane-replicated write data, computed from the incoming entry
  always_comb begin
    strb_c  = 4'b0000;
    wdata_c = in_store_data;
    case (in_mem_op)
      ST_B: begin
        strb_c  = 4'b0001 << in_alu_result[1:0];
        wdata_c = {4{in_store_data[7:0]}};
      end
      ST_H: begin
        strb_c  = in_alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{in_store_data[15:0]}};
      end
      ST_W:    strb_c = 4'b1111;
      default: strb_c = 4'b0000;
    endcase
  end

  // Load data lane selection and sign/zero extension
  always_comb begin
    ld_byte_c   = dresp_rdata[7:0];
    ld_half_c   = lane_q[1] ? dresp_rdata[31:16] : dresp_rdata[15:0];
    load_data_c = dresp_rdata;
    case (lane_q)
      2'd1:    ld_byte_c = dresp_rdata[15:8];
      2'd2:    ld_byte_c = dresp_rdata[23:16];
      2'd3:    ld_byte_c = dresp_rdata[31:24];
      default: ld_byte_c = dresp_rdata[7:0];
    endcase
    case (op_q)
      LD_B:    load_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      LD_H:    load_data_c = {{16{ld_half_c[15]}}, ld_half_c};
      LD_BU:   load_data_c = {24'd0, ld_byte_c};
      LD_HU:   load_data_c = {16'd0, ld_half_c};
      default: load_data_c = dresp_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      kill        <= 1'b0;
      op_q        <= 4'd0;
      lane_q      <= 2'd0;
      ts_valid    <= 1'b0;
      dreq_valid  <= 1'b0;
      dreq_we     <= 1'b0;
      dreq_addr   <= '0;
      dreq_wstrb  <= 4'd0;
      dreq_wdata  <= '0;
      out_pc      <= '0;
      out_inst    <= 32'd0;
      out_rw_data <= '0;
      out_rw_addr <= 5'd0;
      out_rw_en   <= 1'b0;
`ifdef MEM_ALE_EN
      out_ale     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: ;
        REQ: begin
          if (flush) kill <= 1'b1;
          if (dreq_ready) begin
            dreq_valid <= 1'b0;
            // Only loads/stores reach REQ, so op bit 3 clear means load
            if (!op_q[3]) begin
              state <= RESP;
            end else if (kill | flush) begin
              state <= IDLE;
              kill  <= 1'b0;
            end else begin
              state    <= HOLD;
              ts_valid <= 1'b1;
            end
          end
        end
        RESP: begin
          if (flush) kill <= 1'b1;
          if (dresp_valid) begin
            if (kill | flush) begin
              state <= IDLE;
              kill  <= 1'b0;
            end else begin
              state       <= HOLD;
              ts_valid    <= 1'b1;
              out_rw_data <= load_data_c;
            end
          end
        end
        HOLD: begin
          if (flush | ns_ready) begin
            state    <= IDLE;
            ts_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Capture overrides the state update; only possible from IDLE or a draining HOLD
      if (cap_c) begin
        kill        <= 1'b0;
        op_q        <= in_mem_op;
        lane_q      <= in_alu_result[1:0];
        out_pc      <= in_pc;
        out_inst    <= in_inst;
        out_rw_data <= in_alu_result;
        out_rw_addr <= in_rw_addr;
        out_rw_en   <= in_rw_en & ~misalign_c;
        dreq_we     <= is_store_c;
        dreq_addr   <= ADDR_WIDTH'({in_alu_result[DATA_WIDTH-1:2], 2'b00});
        dreq_wstrb  <= strb_c;
        dreq_wdata  <= wdata_c;
        if (is_mem_c & ~misalign_c) begin
          state      <= REQ;
          ts_valid   <= 1'b0;
          dreq_valid <= 1'b1;
        end else begin
          state    <= HOLD;
          ts_valid <= 1'b1;
        end
`ifdef MEM_ALE_EN
        out_ale <= is_mem_c & misalign_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized traffic against
// a transaction-level model of the stage. Build with +define+MEM_ALE_EN to cover out_ale.
`timescale 1ns/1ps

module tb_mem_access;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ls_valid, ts_ready, ts_valid, ns_ready, flush;
  logic [31:0] in_pc, in_inst, in_alu_result, in_store_data;
  logic [4:0]  in_rw_addr;
  logic        in_rw_en;
  logic [3:0]  in_mem_op;
  logic        dreq_valid, dreq_ready, dreq_we;
  logic [31:0] dreq_addr, dreq_wdata;
  logic [3:0]  dreq_wstrb;
  logic        dresp_valid;
  logic [31:0] dresp_rdata;
  logic [31:0] out_pc, out_inst, out_rw_data;
  logic [4:0]  out_rw_addr;
  logic        out_rw_en;
`ifdef MEM_ALE_EN
  logic        out_ale;
`endif

  mem_access #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ls_valid(ls_valid), .ts_ready(ts_ready), .ts_valid(ts_valid),
    .ns_ready(ns_ready), .flush(flush),
    .in_pc(in_pc), .in_inst(in_inst), .in_alu_result(in_alu_result),
    .in_store_data(in_store_data), .in_rw_addr(in_rw_addr), .in_rw_en(in_rw_en),
    .in_mem_op(in_mem_op),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we),
    .dreq_addr(dreq_addr), .dreq_wstrb(dreq_wstrb), .dreq_wdata(dreq_wdata),
    .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
    .out_pc(out_pc), .out_inst(out_inst), .out_rw_data(out_rw_data),
    .out_rw_addr(out_rw_addr), .out_rw_en(out_rw_en)
`ifdef MEM_ALE_EN
    , .out_ale(out_ale)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic bit f_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic bit f_store(input logic [3:0] op);
    return (op >= 4'd9) && (op <= 4'd11);
  endfunction

  function automatic logic [31:0] f_ldata(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * a[1:0])) & 32'hFF;
    h = (rd >> (16 * a[1])) & 32'hFFFF;
    case (op)
      4'd1:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
      4'd2:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      4'd4:    return b;
      4'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] f_strb(input logic [3:0] op, input logic [31:0] a);
    case (op)
      4'd9:    return 4'(32'd1 << a[1:0]);
      4'd10:   return 4'(32'd3 << (2 * a[1]));
      4'd11:   return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [3:0] op, input logic [31:0] sd);
    case (op)
      4'd9:    return (sd & 32'hFF) * 32'h0101_0101;
      4'd10:   return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic bit f_misal(input logic [3:0] op, input logic [31:0] a);
`ifdef MEM_ALE_EN
    return ((op == 4'd2 || op == 4'd5 || op == 4'd10) && a[0]) ||
           ((op == 4'd3 || op == 4'd11) && (a[1:0] != 2'd0));
`else
    return (op == 4'd15) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  // ---------------- transaction-level model ----------------
  bit          occ, held, req_pend, resp_pend, killed, e_ale, m_cap, m_done;
  logic [31:0] e_pc, e_inst, e_data, e_a, e_sd;
  logic [4:0]  e_rd;
  logic        e_en;
  logic [3:0]  e_op;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      occ = 0; held = 0; req_pend = 0; resp_pend = 0; killed = 0;
    end else begin
      chk("m_ts_valid", ts_valid, held);
      chk("m_ts_ready", ts_ready, !occ || (held && ns_ready));
      chk("m_dreq_valid", dreq_valid, req_pend);
      if (req_pend) begin
        chk("m_dreq_addr", dreq_addr, e_a & 32'hFFFF_FFFC);
        chk("m_dreq_we", dreq_we, f_store(e_op));
        chk("m_dreq_wstrb", dreq_wstrb, f_strb(e_op, e_a));
        chk("m_dreq_wdata", dreq_wdata, f_wdata(e_op, e_sd));
      end
      if (held) begin
        chk("m_out_pc", out_pc, e_pc);
        chk("m_out_inst", out_inst, e_inst);
        chk("m_out_rw_data", out_rw_data, e_data);
        chk("m_out_rw_addr", out_rw_addr, e_rd);
        chk("m_out_rw_en", out_rw_en, e_en);
`ifdef MEM_ALE_EN
        chk("m_out_ale", out_ale, e_ale);
`endif
      end

      // Advance across the coming rising edge using the inputs now stable
      m_cap  = ls_valid && !flush && (!occ || (held && ns_ready));
      m_done = 0;
      if (occ && held) begin
        if (flush || ns_ready) begin occ = 0; held = 0; end
      end else if (occ) begin
        if (flush) killed = 1;
        if (resp_pend && dresp_valid) begin
          resp_pend = 0;
          e_data    = f_ldata(e_op, e_a, dresp_rdata);
          m_done    = 1;
        end else if (req_pend && dreq_ready) begin
          req_pend = 0;
          if (f_load(e_op)) resp_pend = 1;
          else m_done = 1;
        end
        if (m_done) begin
          if (killed) occ = 0;
          else held = 1;
        end
      end
      if (m_cap) begin
        occ = 1; killed = 0; held = 0; req_pend = 0; resp_pend = 0; e_ale = 0;
        e_pc = in_pc; e_inst = in_inst; e_data = in_alu_result; e_a = in_alu_result;
        e_sd = in_store_data; e_rd = in_rw_addr; e_en = in_rw_en; e_op = in_mem_op;
        if (f_load(in_mem_op) || f_store(in_mem_op)) begin
          if (f_misal(in_mem_op, in_alu_result)) begin
            held = 1; e_en = 0; e_ale = 1;
          end else begin
            req_pend = 1;
          end
        end else begin
          held = 1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ls_valid = 0; flush = 0; ns_ready = 1; dreq_ready = 0; dresp_valid = 0;
    dresp_rdata = 0; in_pc = 0; in_inst = 0; in_alu_result = 0; in_store_data = 0;
    in_rw_addr = 0; in_rw_en = 0; in_mem_op = 0;
  endtask

  // Issue one load/store, accept it after rdly stalled cycles, return what the DUT showed
  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rd, input int rdly,
                         output logic [31:0] q_addr, output logic [3:0] q_strb,
                         output logic [31:0] q_wdata, output logic q_we,
                         output logic [31:0] res, output logic vld);
    in_mem_op = op; in_alu_result = addr; in_store_data = sd; in_pc = 32'h0000_0400;
    in_inst = 32'h0000_0013; in_rw_addr = 5'd7; in_rw_en = f_load(op);
    ls_valid = 1; ns_ready = 1;
    step();
    ls_valid = 0;
    @(negedge clk);
    q_addr = dreq_addr; q_strb = dreq_wstrb; q_wdata = dreq_wdata; q_we = dreq_we;
    step();
    repeat (rdly) step();
    dreq_ready = 1;
    step();
    dreq_ready = 0;
    if (f_load(op)) begin
      dresp_valid = 1; dresp_rdata = rd;
      step();
      dresp_valid = 0;
    end
    @(negedge clk);
    res = out_rw_data; vld = ts_valid;
    step();
  endtask

  logic [31:0] q_addr, q_wdata, res;
  logic [3:0]  q_strb;
  logic        q_we, vld;

  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ts_valid", ts_valid, 0);
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_ts_ready", ts_ready, 1);
    chk("rst_out_rw_data", out_rw_data, 0);
    chk("rst_dreq_addr", dreq_addr, 0);
    chk("rst_out_pc", out_pc, 0);
    rst = 0;
    step();

    // ALU op, one-cycle latency
    in_mem_op = 4'd0; in_alu_result = 32'h1234; ls_valid = 1; ns_ready = 1;
    step();
    ls_valid = 0;
    @(negedge clk);
    chk("alu_ts_valid", ts_valid, 1);
    chk("alu_rw_data", out_rw_data, 32'h1234);
    step();

    run_mem(4'd1, 32'h1003, 0, 32'h80FF_FF00, 1, q_addr, q_strb, q_wdata, q_we, res, vld);
    chk("ldb_addr", q_addr, 32'h1000);
    chk("ldb_we", q_we, 0);
    chk("ldb_data", res, 32'hFFFF_FF80);
    chk("ldb_valid", vld, 1);
    run_mem(4'd4, 32'h1003, 0, 32'h80FF_FF00, 0, q_addr, q_strb, q_wdata, q_we, res, vld);
    chk("ldbu_data", res, 32'h0000_0080);

    run_mem(4'd10, 32'h2002, 32'hABCD, 0, 2, q_addr, q_strb, q_wdata, q_we, res, vld);
    chk("sth_wstrb", q_strb, 4'b1100);
    chk("sth_wdata", q_wdata, 32'hABCD_ABCD);
    chk("sth_addr", q_addr, 32'h2000);
    chk("sth_we", q_we, 1);
    chk("sth_valid", vld, 1);

    // LD.W stalled three cycles, then flushed while waiting for the response
    in_mem_op = 4'd3; in_alu_result = 32'h4000; ls_valid = 1;
    step();
    ls_valid = 0;
    repeat (3) begin
      @(negedge clk);
      chk("fl_req_valid", dreq_valid, 1);
      chk("fl_req_addr", dreq_addr, 32'h4000);
      step();
    end
    dreq_ready = 1;
    step();
    dreq_ready = 0; flush = 1;
    step();
    flush = 0;
    @(negedge clk);
    chk("fl_resp_wait", ts_ready, 0);
    chk("fl_no_valid", ts_valid, 0);
    step();
    dresp_valid = 1; dresp_rdata = 32'hDEAD_BEEF;
    step();
    dresp_valid = 0;
    @(negedge clk);
    chk("fl_end_valid", ts_valid, 0);
    chk("fl_end_idle", ts_ready, 1);
    step();

    // Back-to-back ALU ops, no bubble
    in_mem_op = 4'd0; in_alu_result = 32'h11; ls_valid = 1;
    step();
    in_alu_result = 32'h22;
    @(negedge clk);
    chk("b2b_v1", ts_valid, 1);
    chk("b2b_d1", out_rw_data, 32'h11);
    step();
    ls_valid = 0;
    @(negedge clk);
    chk("b2b_v2", ts_valid, 1);
    chk("b2b_d2", out_rw_data, 32'h22);
    step();
    @(negedge clk);
    chk("b2b_drain", ts_valid, 0);
    step();

`ifdef MEM_ALE_EN
    in_mem_op = 4'd3; in_alu_result = 32'h1002; in_rw_en = 1; ls_valid = 1;
    step();
    ls_valid = 0;
    @(negedge clk);
    chk("ale_no_req", dreq_valid, 0);
    chk("ale_valid", ts_valid, 1);
    chk("ale_flag", out_ale, 1);
    chk("ale_rw_en", out_rw_en, 0);
    step();
`endif

    // Asynchronous reset in the middle of a request
    in_mem_op = 4'd3; in_alu_result = 32'h3000; ls_valid = 1;
    step();
    ls_valid = 0;
    @(negedge clk);
    chk("arst_pre", dreq_valid, 1);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_dreq", dreq_valid, 0);
    chk("arst_ts_valid", ts_valid, 0);
    #1 rst = 0;
    step();

    // Randomized traffic, checked every cycle by the model
    repeat (3000) begin
      ls_valid      = ($urandom_range(0, 3) != 0);
      in_pc         = $urandom;
      in_inst       = $urandom;
      in_alu_result = $urandom;
      in_store_data = $urandom;
      in_rw_addr    = 5'($urandom);
      in_rw_en      = 1'($urandom);
      in_mem_op     = 4'($urandom_range(0, 15));
      flush         = ($urandom_range(0, 9) == 0);
      ns_ready      = ($urandom_range(0, 3) != 0);
      dreq_ready    = ($urandom_range(0, 2) == 0);
      dresp_valid   = ($urandom_range(0, 2) == 0);
      dresp_rdata   = $urandom;
      step();
    end
    idle_inputs();
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
